// File: rtl/bus_transfer_sequencer.sv
// Sequences one {src,dst} register move at a time over a shared tri-state bus.
// Optional BUS_TURNAROUND_EN adds a one-cycle idle-bus TURN state after RELEASE.
module bus_transfer_sequencer #(
  parameter int unsigned NUM_REGS      = 8,
  parameter int unsigned SEL_WIDTH     = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [SEL_WIDTH-1:0] cmd_src,
  input  logic [SEL_WIDTH-1:0] cmd_dst,
  output logic [NUM_REGS-1:0]  reg_oe,
  output logic [NUM_REGS-1:0]  reg_notLoad,
  output logic                 ext_grant,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StLoad,
    StRelease,
    StTurn
  } state_e;

  // A source index equal to NUM_REGS selects the external driver.
  localparam logic [SEL_WIDTH-1:0] ExtSel     = SEL_WIDTH'(NUM_REGS);
  localparam logic [NUM_REGS-1:0]  OneHotLsb  = NUM_REGS'(1);
  localparam logic [3:0]           SettleLoad = 4'(SETTLE_CYCLES - 1);

  state_e               state_q;
  logic [3:0]           settle_q;
  logic [SEL_WIDTH-1:0] dst_q;
  logic                 cmd_legal;

  assign cmd_legal = (cmd_dst < ExtSel) && (cmd_src <= ExtSel) && (cmd_src != cmd_dst);
  assign cmd_ready = (state_q == StIdle) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      settle_q    <= 4'd0;
      dst_q       <= '0;
      reg_oe      <= '0;
      reg_notLoad <= '1;
      ext_grant   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (cmd_legal) begin
              dst_q    <= cmd_dst;
              settle_q <= SettleLoad;
              busy     <= 1'b1;
              state_q  <= StDrive;
              if (cmd_src == ExtSel) begin
                ext_grant <= 1'b1;
              end else begin
                reg_oe <= OneHotLsb << cmd_src;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        StDrive: begin
          if (settle_q == 4'd0) begin
            reg_notLoad <= ~(OneHotLsb << dst_q);
            state_q     <= StLoad;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        StLoad: begin
          // Destination captured on the edge ending LOAD; drop every strobe together.
          reg_oe      <= '0;
          ext_grant   <= 1'b0;
          reg_notLoad <= '1;
          done        <= 1'b1;
          state_q     <= StRelease;
        end
        StRelease: begin
`ifdef BUS_TURNAROUND_EN
          state_q <= StTurn;
`else
          busy    <= 1'b0;
          state_q <= StIdle;
`endif
        end
        StTurn: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
